// File: rtl/dac_sweep_tx_if.sv
// Host/DAC signal bundle for the sweep playback engine.
// master = host side (table writes, start/abort), slave = engine side.
interface dac_sweep_tx_if;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [11:0] wr_data;
  logic        start;
  logic        abort;
  logic        busy;
  logic        done;
  logic        dac_sync_n;
  logic        dac_sclk;
  logic        dac_din;

  modport master (
    output wr_en, wr_addr, wr_data, start, abort,
    input  busy, done, dac_sync_n, dac_sclk, dac_din
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, abort,
    output busy, done, dac_sync_n, dac_sclk, dac_din
  );
endinterface

// File: rtl/dac_sweep_tx.sv
// Plays a NUM_POINTS code table once per start into a 16-bit SPI DAC, one frame every
// SAMPLE_PERIOD clocks; start is dropped while busy, abort returns to idle on the next edge.
module dac_sweep_tx #(
  parameter int         NUM_POINTS    = 200,
  parameter int         CLK_DIV       = 2,
  parameter int         SAMPLE_PERIOD = 80,
  parameter logic [1:0] PD_MODE       = 2'b00
) (
  input logic           clk,
  input logic           rst_n,
  dac_sweep_tx_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, GAP} state_t;

  localparam logic [7:0]  LAST_PT  = 8'(NUM_POINTS - 1);
  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST = 16'(SAMPLE_PERIOD - 3);
  localparam logic [5:0]  END_HALF = 6'd33;

  state_t      state, state_nxt;
  logic [11:0] mem [256];
  logic [11:0] rd_code;
  logic [15:0] frame_word, shreg, div_cnt, sp_cnt;
  logic [7:0]  point;
  logic [5:0]  half, half_nxt;
  logic        sync_n, sclk, din, busy, done;
  logic        loading, tick, frame_end, last_pt, gap_end;

  always_ff @(posedge clk) begin
    if (bus.wr_en && (32'(bus.wr_addr) < NUM_POINTS)) mem[bus.wr_addr] <= bus.wr_data;
    rd_code <= mem[point];
  end

  // SYNC_n is still high only on the first SHIFT cycle, which loads the frame.
  assign loading    = (state == SHIFT) && sync_n;
  assign tick       = (state == SHIFT) && !sync_n && (div_cnt == DIV_LAST);
  assign half_nxt   = half + 6'd1;
  assign frame_end  = tick && (half_nxt == END_HALF);
  assign last_pt    = (point == LAST_PT);
  assign gap_end    = (sp_cnt >= GAP_LAST);
  assign frame_word = {2'b00, PD_MODE, rd_code};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.start) state_nxt = FETCH;
        FETCH:   state_nxt = SHIFT;
        SHIFT:   if (frame_end) state_nxt = last_pt ? IDLE : GAP;
        GAP:     if (gap_end) state_nxt = FETCH;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      point   <= 8'd0;
      sync_n  <= 1'b1;
      sclk    <= 1'b1;
      din     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      shreg   <= '0;
      div_cnt <= '0;
      half    <= '0;
      sp_cnt  <= '0;
    end else begin
      done   <= 1'b0;
      sp_cnt <= loading ? 16'd0 : sp_cnt + 16'd1;
      if (bus.abort) begin
        sync_n <= 1'b1;
        sclk   <= 1'b1;
        din    <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          IDLE: if (bus.start) begin
            busy  <= 1'b1;
            point <= 8'd0;
          end
          SHIFT: begin
            if (loading) begin
              shreg   <= frame_word;
              sync_n  <= 1'b0;
              din     <= frame_word[15];
              div_cnt <= '0;
              half    <= '0;
            end else if (tick) begin
              div_cnt <= '0;
              half    <= half_nxt;
              // Odd half-periods are falling edges; even ones rise and advance DIN.
              if (frame_end) begin
                sync_n <= 1'b1;
                din    <= 1'b0;
                if (last_pt) begin
                  done <= 1'b1;
                  busy <= 1'b0;
                end
              end else if (half_nxt[0]) begin
                sclk <= 1'b0;
              end else begin
                sclk <= 1'b1;
                if (half_nxt < 6'd31) begin
                  shreg <= {shreg[14:0], 1'b0};
                  din   <= shreg[14];
                end
              end
            end else begin
              div_cnt <= div_cnt + 16'd1;
            end
          end
          GAP: if (gap_end) point <= point + 8'd1;
          default: ;
        endcase
      end
    end
  end

  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.dac_sync_n = sync_n;
  assign bus.dac_sclk   = sclk;
  assign bus.dac_din    = din;
endmodule
